// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
package dmem_pkg;

  // Controller FSM encoding.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRamAcc  = 2'd1,
    StRomWait = 2'd2,
    StResp    = 2'd3
  } dmem_state_e;

  // Number of upper address bits compared to select a region.
  localparam int unsigned REGION_W = 16;

  // Expand a byte-enable mask (up to 8 lanes) into a per-bit mask.
  function automatic logic [63:0] expand_mask(input logic [7:0] mask);
    logic [63:0] bits;
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      bits[i*8 +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Load/store request/response bus plus the ROM data port of the data memory controller.
// master: the core side (drives requests, consumes responses, supplies rom_rdata).
// slave:  the controller.
interface data_memory_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_mask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_fault;
  logic [31:0]           rom_addr;
  logic [DATA_W-1:0]     rom_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready, rom_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rom_addr
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready, rom_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rom_addr
  );
endinterface

// File: rtl/dmem_ram_bank.sv
// Single-port synchronous RAM with byte-enable write and registered read.
// Contents are not reset.
module dmem_ram_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RAM_WORDS = 1024,
  localparam int unsigned IdxW     = $clog2(RAM_WORDS)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [IdxW-1:0]     idx_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] mask_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [RAM_WORDS];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] bitmask;

  assign bitmask = DATA_W'(expand_mask(8'(mask_i)));
  assign rdata_o = rdata_q;

  // Byte-merged write: lanes with a clear mask bit keep their old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= (mem_q[idx_i] & ~bitmask) | (wdata_i & bitmask);
    end
  end

  // Registered read, only updated when a load is issued.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked load/store backend: decodes RAM/ROM regions, writes/reads the RAM bank and
// fetches ROM words with ROM_WAIT wait states. One outstanding request; the response is
// held until consumed.
// Optional feature macro: DMEM_ACCESS_FAULT_EN -- when defined, rsp_fault flags unmapped,
// misaligned and ROM-store accesses; otherwise rsp_fault is tied to 0.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter int unsigned ROM_WAIT  = 1
) (
  input logic               clk,
  input logic               reset,
  data_memory_ctrl_if.slave dmem_bus
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);
  localparam int unsigned IdxW = $clog2(RAM_WORDS);
  localparam int unsigned CntW = (ROM_WAIT < 2) ? 1 : $clog2(ROM_WAIT + 1);

  dmem_state_e       state_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [31:0]       rom_addr_q;
  logic [CntW-1:0]   cnt_q;
  logic              store_q;

  logic              accept;
  logic              is_ram;
  logic              is_rom;
  logic              aligned;
  logic              ram_ok;
  logic              rom_load;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr;

  // Request decode; only meaningful while idle.
  always_comb begin
    accept   = dmem_bus.req_valid && (state_q == StIdle);
    is_ram   = dmem_bus.req_addr[31 -: REGION_W] == RAM_BASE[31 -: REGION_W];
    is_rom   = dmem_bus.req_addr[31 -: REGION_W] == ROM_BASE[31 -: REGION_W];
    aligned  = dmem_bus.req_addr[OffW-1:0] == '0;
    // RAM wins if both bases decode to the same region.
    ram_ok   = is_ram && aligned;
    rom_load = !is_ram && is_rom && aligned && !dmem_bus.req_write;
    ram_we   = accept && ram_ok && dmem_bus.req_write;
    ram_re   = accept && ram_ok && !dmem_bus.req_write;
  end

  // Address bits above the RAM index alias silently inside the region.
  assign unused_addr = ^dmem_bus.req_addr;

  dmem_ram_bank #(
    .DATA_W    (DATA_W),
    .RAM_WORDS (RAM_WORDS)
  ) u_ram_bank (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (dmem_bus.req_addr[OffW +: IdxW]),
    .wdata_i (dmem_bus.req_wdata),
    .mask_i  (dmem_bus.req_mask),
    .rdata_o (ram_rdata)
  );

`ifdef DMEM_ACCESS_FAULT_EN
  logic rsp_fault_q;

  // Fault flag is latched at accept and held with the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_fault_q <= 1'b0;
    end else if (accept) begin
      rsp_fault_q <= !(ram_ok || rom_load);
    end else if (state_q == StResp && dmem_bus.rsp_ready) begin
      rsp_fault_q <= 1'b0;
    end
  end

  assign dmem_bus.rsp_fault = rsp_fault_q;
`else
  assign dmem_bus.rsp_fault = 1'b0;
`endif

  // Main FSM with registered response and ROM address outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rom_addr_q  <= '0;
      cnt_q       <= '0;
      store_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            store_q <= dmem_bus.req_write;
            if (ram_ok) begin
              state_q <= StRamAcc;
            end else if (rom_load) begin
              rom_addr_q <= dmem_bus.req_addr;
              cnt_q      <= CntW'(ROM_WAIT);
              state_q    <= StRomWait;
            end else begin
              // Unmapped, misaligned or ROM store: no side effect, read 0.
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= StResp;
            end
          end
        end
        StRamAcc: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= store_q ? '0 : ram_rdata;
          state_q     <= StResp;
        end
        StRomWait: begin
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= dmem_bus.rom_rdata;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (dmem_bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmem_bus.req_ready = (state_q == StIdle);
  assign dmem_bus.rsp_valid = rsp_valid_q;
  assign dmem_bus.rsp_rdata = rsp_rdata_q;
  assign dmem_bus.rom_addr  = rom_addr_q;

endmodule
